alu_32bit: RTL and testbench

- Registered 32-bit MIPS R-type ALU; executes the operation selected by the 6-bit MIPS funct field on operands A_in/B_in.
- Sits in the EX stage, fed by the decoder's funct field and the register-file/forwarding operands.
- Produces the result plus Branch_out (compare-taken) and Jump_out (register-jump) flags.
- All outputs registered: 1-cycle latency.

---
 rtl/alu_32bit_if.sv | 31 +++
 rtl/alu_32bit.sv | 104 ++++++++++
 tb/tb_alu_32bit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/alu_32bit_if.sv
// Operand/result bundle between the EX-stage issue logic and the ALU.
// Combinational wires only; the ALU registers results one cycle later.
// No backpressure: a new operation is presented every cycle.
interface alu_32bit_if;
    logic [5:0]  Func_in;
    logic [31:0] A_in;
    logic [31:0] B_in;
    logic [31:0] O_out;
    logic        Branch_out;
    logic        Jump_out;

    // Issue side: drives funct and operands, observes registered results
    modport master (
        output Func_in,
        output A_in,
        output B_in,
        input  O_out,
        input  Branch_out,
        input  Jump_out
    );

    // ALU side: consumes funct and operands, drives registered results
    modport slave (
        input  Func_in,
        input  A_in,
        input  B_in,
        output O_out,
        output Branch_out,
        output Jump_out
    );
endinterface

// File: rtl/alu_32bit.sv
// Registered 32-bit MIPS R-type ALU with branch-compare and register-jump flags.
// Latency: exactly 1 cycle from Func_in/A_in/B_in to O_out/Branch_out/Jump_out.
// No backpressure: accepts a new operation on every rising clock edge.
module alu_32bit (
    input  logic         Clk_in,
    input  logic         Reset_in,
    alu_32bit_if.slave   bus
);

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_JALR = 6'b001001;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;
    localparam logic [5:0] FN_BEQ  = 6'b111100;
    localparam logic [5:0] FN_BNE  = 6'b111101;

    logic [31:0] o_d,  o_q;
    logic        br_d, br_q;
    logic        jmp_d, jmp_q;

    logic [4:0]  sh;
    logic [31:0] diff;
    logic        a_eq_b;
    logic        lt_signed;
    logic        lt_unsigned;

    // Shared datapath terms: shift amount, subtractor and comparators
    always_comb begin
        sh          = bus.B_in[4:0];
        diff        = bus.A_in - bus.B_in;
        a_eq_b      = (bus.A_in == bus.B_in);
        lt_signed   = ($signed(bus.A_in) < $signed(bus.B_in));
        lt_unsigned = (bus.A_in < bus.B_in);
    end

    // Decode funct into next result and flags; unknown codes yield all zero
    always_comb begin
        o_d   = 32'h0;
        br_d  = 1'b0;
        jmp_d = 1'b0;
        case (bus.Func_in)
            FN_SLL,  FN_SLLV: o_d = bus.A_in << sh;
            FN_SRL,  FN_SRLV: o_d = bus.A_in >> sh;
            FN_SRA,  FN_SRAV: o_d = $unsigned($signed(bus.A_in) >>> sh);
            FN_JR,   FN_JALR: begin
                o_d   = bus.A_in;
                jmp_d = 1'b1;
            end
            FN_ADD,  FN_ADDU: o_d = bus.A_in + bus.B_in;
            FN_SUB,  FN_SUBU: o_d = diff;
            FN_AND:           o_d = bus.A_in & bus.B_in;
            FN_OR:            o_d = bus.A_in | bus.B_in;
            FN_XOR:           o_d = bus.A_in ^ bus.B_in;
            FN_NOR:           o_d = ~(bus.A_in | bus.B_in);
            FN_SLT:           o_d = {31'h0, lt_signed};
            FN_SLTU:          o_d = {31'h0, lt_unsigned};
            FN_BEQ: begin
                o_d  = diff;
                br_d = a_eq_b;
            end
            FN_BNE: begin
                o_d  = diff;
                br_d = ~a_eq_b;
            end
            default: begin
                o_d   = 32'h0;
                br_d  = 1'b0;
                jmp_d = 1'b0;
            end
        endcase
    end

    // Output registers; reset clears them without waiting for a clock edge
    always_ff @(posedge Clk_in or posedge Reset_in) begin
        if (Reset_in) begin
            o_q   <= 32'h0;
            br_q  <= 1'b0;
            jmp_q <= 1'b0;
        end else begin
            o_q   <= o_d;
            br_q  <= br_d;
            jmp_q <= jmp_d;
        end
    end

    assign bus.O_out      = o_q;
    assign bus.Branch_out = br_q;
    assign bus.Jump_out   = jmp_q;

endmodule

// File: tb/tb_alu_32bit.sv
// Self-checking bench for alu_32bit: directed literal cases plus randomized
// traffic compared every cycle against a behavioural model of the funct table.
module tb_alu_32bit;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    bit   chk_en = 1'b0;

    alu_32bit_if alu_if ();

    alu_32bit dut (
        .Clk_in   (clk),
        .Reset_in (rst),
        .bus      (alu_if)
    );

    always #5 clk = ~clk;

    // Behavioural model: returns {O, Branch, Jump}
    function automatic logic [33:0] model(input logic [5:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        int unsigned sh;
        logic [31:0] o;
        logic br, j;
        sh = int'(b % 32);
        o = 0; br = 0; j = 0;
        case (f)
            6'd0, 6'd4: o = a << sh;
            6'd2, 6'd6: o = a >> sh;
            6'd3, 6'd7: o = a[31] ? ~((~a) >> sh) : (a >> sh);
            6'd8, 6'd9: begin o = a; j = 1; end
            6'd32, 6'd33: o = a + b;
            6'd34, 6'd35: o = a - b;
            6'd36: o = a & b;
            6'd37: o = a | b;
            6'd38: o = a ^ b;
            6'd39: o = ~(a | b);
            6'd42: o = (a[31] != b[31]) ? {31'h0, a[31]} : {31'h0, a < b};
            6'd43: o = {31'h0, a < b};
            6'd60: begin o = a - b; br = (a == b); end
            6'd61: begin o = a - b; br = (a != b); end
            default: begin o = 0; br = 0; j = 0; end
        endcase
        return {o, br, j};
    endfunction

    logic [33:0] exp_q = '0;

    // Expected outputs track the model, registered on the same edges as the DUT
    always @(posedge clk or posedge rst) begin
        if (rst) exp_q = '0;
        else     exp_q = model(alu_if.Func_in, alu_if.A_in, alu_if.B_in);
    end

    // Per-cycle comparison against the model, mid-cycle
    always @(negedge clk) begin
        if (chk_en) begin
            tests++;
            if ({alu_if.O_out, alu_if.Branch_out, alu_if.Jump_out} !== exp_q) begin
                fails++;
                $display("FAIL model t=%0t got O=%h br=%b j=%b want O=%h br=%b j=%b",
                         $time, alu_if.O_out, alu_if.Branch_out, alu_if.Jump_out,
                         exp_q[33:2], exp_q[1], exp_q[0]);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] eo,
                         input logic ebr, input logic ej);
        tests++;
        if (alu_if.O_out !== eo || alu_if.Branch_out !== ebr || alu_if.Jump_out !== ej) begin
            fails++;
            $display("FAIL %s got O=%h br=%b j=%b want O=%h br=%b j=%b", name,
                     alu_if.O_out, alu_if.Branch_out, alu_if.Jump_out, eo, ebr, ej);
        end
    endtask

    // Drive inputs, take one edge, check literal expectation just after it
    task automatic op(input string name, input logic [5:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] eo,
                      input logic ebr, input logic ej);
        alu_if.Func_in = f;
        alu_if.A_in    = a;
        alu_if.B_in    = b;
        @(posedge clk); #1;
        check(name, eo, ebr, ej);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h7FFFFFFF;
            4: return $urandom_range(0, 40);
            default: return $urandom;
        endcase
    endfunction

    logic [5:0] legal [20] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd8, 6'd9,
                               6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38,
                               6'd39, 6'd42, 6'd43, 6'd60, 6'd61};

    initial begin
        alu_if.Func_in = 6'd32;
        alu_if.A_in    = 32'h1111;
        alu_if.B_in    = 32'h2222;
        rst = 1'b1;
        #2;
        check("reset_initial", 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("reset_held", 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        chk_en = 1'b1;
        @(posedge clk); #1;
        check("first_edge_after_reset", 32'h3333, 1'b0, 1'b0);

        // Shifts
        op("sll",   6'b000000, 32'h55555555, 32'd3,  32'hAAAAAAA8, 0, 0);
        op("sllv",  6'b000100, 32'h555557FF, 32'd4,  32'h55557FF0, 0, 0);
        op("srl",   6'b000010, 32'h555557FF, 32'd4,  32'h0555557F, 0, 0);
        op("srlv",  6'b000110, 32'h555557FF, 32'd4,  32'h0555557F, 0, 0);
        op("sra",   6'b000011, 32'h555557FF, 32'd4,  32'h0555557F, 0, 0);
        op("srav",  6'b000111, 32'hD55557FF, 32'd4,  32'hFD55557F, 0, 0);
        op("sra0",  6'b000011, 32'h8000F00D, 32'h20, 32'h8000F00D, 0, 0);
        op("sra31", 6'b000011, 32'h80000000, 32'd31, 32'hFFFFFFFF, 0, 0);
        op("sllhi", 6'b000000, 32'h00000001, 32'hFFFFFFE1, 32'h00000002, 0, 0);

        // Arithmetic and logic
        op("add_wrap", 6'b100000, 32'hFFFFFFFF, 32'd1, 32'h0, 0, 0);
        op("sub_wrap", 6'b100010, 32'h0, 32'd1, 32'hFFFFFFFF, 0, 0);
        op("nor",      6'b100111, 32'h0, 32'h0, 32'hFFFFFFFF, 0, 0);
        op("xor",      6'b100110, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, 0);
        op("slt",      6'b101010, 32'h80000000, 32'h0, 32'h1, 0, 0);
        op("sltu",     6'b101011, 32'h80000000, 32'h0, 32'h0, 0, 0);

        // Branch and jump
        op("beq", 6'b111100, 32'h1234, 32'h1234, 32'h0, 1, 0);
        op("bne", 6'b111101, 32'h1234, 32'h1234, 32'h0, 0, 0);
        op("bne_taken", 6'b111101, 32'h10, 32'h1, 32'hF, 1, 0);
        op("jr",  6'b001000, 32'h00400020, 32'h0, 32'h00400020, 0, 1);
        op("and_after_jr", 6'b100100, 32'h00400020, 32'h0000FFFF, 32'h20, 0, 0);
        op("illegal", 6'b111111, 32'hDEADBEEF, 32'h12345678, 32'h0, 0, 0);

        // Latency: inputs change between edges, output holds until the edge
        op("lat_a", 6'b100001, 32'd5, 32'd7, 32'd12, 0, 0);
        alu_if.Func_in = 6'b100101;
        alu_if.A_in    = 32'hA0;
        alu_if.B_in    = 32'h0B;
        #3;
        check("lat_hold", 32'd12, 0, 0);
        @(posedge clk); #1;
        check("lat_b", 32'hAB, 0, 0);

        // Reset mid-stream overrides the edge; first edge after release registers inputs
        op("pre_reset", 6'b001001, 32'hCAFE0000, 32'h0, 32'hCAFE0000, 0, 1);
        rst = 1'b1;
        #1;
        check("reset_async", 32'h0, 0, 0);
        @(posedge clk); #1;
        check("reset_over_edge", 32'h0, 0, 0);
        alu_if.Func_in = 6'b111100;
        alu_if.A_in    = 32'h77;
        alu_if.B_in    = 32'h77;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_release", 32'h0, 1, 0);

        // Randomized traffic against the model, with occasional reset pulses
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0)
                alu_if.Func_in = 6'($urandom_range(0, 63));
            else
                alu_if.Func_in = legal[$urandom_range(0, 19)];
            alu_if.A_in = pick_operand();
            alu_if.B_in = ($urandom_range(0, 5) == 0) ? alu_if.A_in : pick_operand();
            rst = ($urandom_range(0, 99) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(posedge clk); #1;

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
